fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_INIT, default 32'h0000_0000, meaning PC value loaded on reset.
REQ-002 SHALL have port CLK  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port ihit  input  1  instruction memory returns valid imemload this cycle.
REQ-005 SHALL have port imemload  input  word_t  instruction word from instruction memory.
REQ-006 SHALL have port imemREN  output  1  instruction read request.
REQ-007 SHALL have port imemaddr  output  word_t  instruction fetch address.
REQ-008 SHALL have port stall  input  1  hazard hold request for IF/ID (load-use).
REQ-009 SHALL have port redirect  input  1  taken branch or jump resolved downstream.
REQ-010 SHALL have port redirect_pc  input  word_t  target address for redirect.
REQ-011 SHALL have port halt  input  1  halt instruction has reached the decision stage.
REQ-012 SHALL have ports ifid_instruction and ifid_PCplus4  output  word_t  values for the IF/ID register's instruction_in and PCplus4_in.
REQ-013 SHALL have ports ifid_enable and ifid_flush  output  1  drive the IF/ID register's enable and flush.

Function
REQ-014 SHALL implement a state machine with states FETCH, PEND and HALTED.
REQ-015 SHALL hold a 32-bit PC register; imemaddr SHALL equal PC in every state.
REQ-016 SHALL drive imemREN=1 in FETCH and PEND and imemREN=0 in HALTED.
REQ-017 SHALL drive ifid_instruction=imemload and ifid_PCplus4=PC+4 combinationally, with the sum taken modulo 2^32 (0xFFFFFFFC+4 = 0).
REQ-018 FETCH, ihit=1, stall=0, redirect=0: SHALL assert ifid_enable=1 and ifid_flush=0, and SHALL set PC to PC+4 at the next edge.
REQ-019 FETCH, ihit=1, stall=1, redirect=0: SHALL assert ifid_enable=0 and ifid_flush=0, and SHALL hold PC.
REQ-020 FETCH, ihit=0, redirect=0: SHALL assert ifid_enable=0 and ifid_flush=0, and SHALL hold PC.
REQ-021 FETCH, redirect=1, ihit=1: SHALL assert ifid_flush=1 and ifid_enable=1, SHALL set PC to {redirect_pc[31:2],2'b00} and SHALL stay in FETCH; redirect SHALL override stall.
REQ-022 FETCH, redirect=1, ihit=0: SHALL latch the aligned redirect_pc into pend_pc, SHALL assert ifid_flush=1, SHALL hold PC (keeps imemaddr stable for the outstanding access) and SHALL go to PEND.
REQ-023 PEND: SHALL assert ifid_flush=1 and ifid_enable=0 every cycle.
REQ-024 PEND, ihit=1: SHALL discard imemload, SHALL set PC to pend_pc and SHALL go to FETCH.
REQ-025 PEND, redirect=1: SHALL overwrite pend_pc with the newer aligned target; if ihit=1 in the same cycle, the new target SHALL be the value loaded into PC.
REQ-026 Any state, halt=1: SHALL go to HALTED at the next edge with PC held; halt SHALL have priority over redirect, stall and ihit.
REQ-027 HALTED: SHALL assert ifid_flush=1 and ifid_enable=0, and SHALL ignore all inputs; only RST leaves HALTED.

Reset
REQ-028 RST=1 SHALL immediately set state=FETCH, PC=PC_INIT and pend_pc=0, independent of CLK.
REQ-029 During reset, outputs SHALL be: imemaddr=PC_INIT, imemREN=1, ifid_enable=0 and ifid_flush=1.
REQ-030 RST asserted in PEND or HALTED SHALL discard the pending target; the first fetch after release SHALL be from PC_INIT.

Structure
REQ-031 fetch_state_t (FETCH, PEND, HALTED) SHALL be declared in cpu_types_pkg; word_t SHALL come from that package.
REQ-032 SHALL be a single module with no sub-modules; PC and pend_pc SHALL be plain registers in one always_ff block with async reset.

Verification
REQ-033 Reset release with ihit=1 for 3 cycles SHALL give imemaddr 0x0, 0x4, 0x8 with ifid_enable=1, and ifid_PCplus4 SHALL be 0x4 in the first cycle.
REQ-034 At PC=0x10, stall=1 for 2 cycles with ihit=1 SHALL hold PC at 0x10 with ifid_enable=0; after release PC SHALL become 0x14.
REQ-035 At PC=0x20, redirect=1 with redirect_pc=0x103 and ihit=1 SHALL assert ifid_flush for 1 cycle, and the next imemaddr SHALL be 0x100.
REQ-036 At PC=0x20, redirect=1 with redirect_pc=0x200 and ihit=0, then ihit=0 for 2 cycles and ihit=1: imemaddr SHALL stay 0x20 throughout PEND, flush SHALL be high, and imemaddr SHALL then be 0x200.
REQ-037 In PEND, a second redirect to 0x300 followed by ihit=1 SHALL make the next imemaddr 0x300.
REQ-038 halt=1 together with redirect=1 SHALL enter HALTED with imemREN=0, the PC unchanged and flush high; an async RST pulse SHALL give imemaddr=PC_INIT without a clock edge.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word and the fetch-stage state encoding.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        PEND   = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, redirect handling around an
// outstanding memory access, and IF/ID enable/flush generation.
module fetch_unit
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
) (
    input  logic  CLK,
    input  logic  RST,
    input  logic  ihit,
    input  word_t imemload,
    output logic  imemREN,
    output word_t imemaddr,
    input  logic  stall,
    input  logic  redirect,
    input  word_t redirect_pc,
    input  logic  halt,
    output word_t ifid_instruction,
    output word_t ifid_PCplus4,
    output logic  ifid_enable,
    output logic  ifid_flush
);

    fetch_state_t state_q, state_d;
    word_t        pc_q, pc_d;
    word_t        pend_pc_q, pend_pc_d;
    word_t        target;
    logic         enable_c;
    logic         flush_c;

    assign target = redirect_pc & 32'hFFFF_FFFC;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= FETCH;
            pc_q      <= PC_INIT;
            pend_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pend_pc_d = pend_pc_q;
        enable_c  = 1'b0;
        flush_c   = 1'b0;
        unique case (state_q)
            FETCH: begin
                if (halt) begin
                    state_d = HALTED;
                    flush_c = 1'b1;
                end else if (redirect) begin
                    flush_c = 1'b1;
                    if (ihit) begin
                        enable_c = 1'b1;
                        pc_d     = target;
                    end else begin
                        // PC stays put so the in-flight access keeps a stable address
                        pend_pc_d = target;
                        state_d   = PEND;
                    end
                end else if (ihit && !stall) begin
                    enable_c = 1'b1;
                    pc_d     = pc_q + 32'd4;
                end
            end
            PEND: begin
                flush_c = 1'b1;
                if (halt) begin
                    state_d = HALTED;
                end else begin
                    if (redirect) begin
                        pend_pc_d = target;
                    end
                    if (ihit) begin
                        pc_d    = redirect ? target : pend_pc_q;
                        state_d = FETCH;
                    end
                end
            end
            HALTED: begin
                flush_c = 1'b1;
            end
            default: begin
                state_d = FETCH;
                flush_c = 1'b1;
            end
        endcase
    end

    assign imemaddr         = pc_q;
    assign imemREN          = (state_q != HALTED);
    assign ifid_instruction = imemload;
    assign ifid_PCplus4     = pc_q + 32'd4;
    assign ifid_enable      = enable_c & ~RST;
    assign ifid_flush       = flush_c | RST;

endmodule
